wb_ram_test_master: RTL and testbench
=====================================

Name: wb_ram_test_master

Overview:
- Wishbone initiator that drives the existing 4x 512x32 RAM responder block from inside the FPGA.
- On command it runs a burst over a chosen RAM:
  - FILL: writes an incrementing pattern.
  - CHECK: reads back and compares against the same pattern, counting mismatches.
- Used for power-on RAM self-test and for preloading buffers before the M4 host reads them.
- Sits beside the AHB bridge; the top level muxes its RAM CYC/STB/ADR onto the RAM block when the bridge is idle.

Parameters:
- ADDRWIDTH, 9, RAM word-address width (512 words).
- DATAWIDTH, 32, data width.
- TIMEOUT_CYC, 255, max cycles waiting for ACK before abort.

Ports:
- WBs_CLK_i  in  1  clock.
- WBs_RST_i  in  1  reset.
- cmd_start_i  in  1  one-cycle start pulse.
- cmd_mode_i  in  1  0=FILL, 1=CHECK.
- cmd_ram_sel_i  in  2  target RAM 0..3.
- cmd_base_i  in  9  start word address.
- cmd_len_i  in  10  word count, 0..512.
- cmd_seed_i  in  32  pattern for word i is seed+i (mod 2^32).
- busy_o  out  1  burst in progress.
- done_o  out  1  one-cycle completion pulse.
- err_cnt_o  out  10  CHECK mismatch count.
- first_err_vld_o  out  1  at least one mismatch seen.
- first_err_adr_o  out  9  word address of first mismatch.
- timeout_o  out  1  last burst aborted on ACK timeout.
- WBm_ADR_o  out  11  address; [10:9]=0, [8:0]=word address.
- WBm_RAM_CYC_o  out  4  one-hot cycle select, bit n = RAM n.
- WBm_BYTE_STB_o  out  4  byte strobes.
- WBm_WE_o  out  1  write enable.
- WBm_STB_o  out  1  strobe.
- WBm_DAT_o  out  32  write data.
- WBm_DAT_i  in  32  read data, muxed from the selected RAM.
- WBm_ACK_i  in  1  acknowledge.

Behaviour:
- Reset is WBs_RST_i, asynchronous, active-high; clock is WBs_CLK_i.
- Reset values: all outputs 0, including ADR, DAT, BYTE_STB, CYC, counters and flags.
- Reset mid-burst drops CYC/STB immediately (asynchronously); no done pulse is generated.

State machine: IDLE, REQ, GAP, FIN.
- IDLE:
  - cmd_start_i with len!=0 latches mode/sel/base/len/seed.
  - Clears err_cnt, first_err_vld, first_err_adr and timeout.
  - Goes to REQ; busy_o=1 from the next cycle.
- Start with len=0: clears the status flags, goes to FIN with no bus cycle; done_o pulses the following cycle.
- cmd_start_i while busy is ignored.
- REQ:
  - CYC bit[sel]=1, STB=1, BYTE_STB=4'hF, WE=~mode.
  - ADR[8:0]=(base+i) mod 512, so addresses wrap past 511 to 0.
  - DAT_o=seed+i in FILL; DAT_o=0 in CHECK.
  - All bus outputs hold stable until ACK.
- On ACK in REQ:
  - CHECK: compare WBm_DAT_i to seed+i. On mismatch, err_cnt increments; the first mismatch sets first_err_vld and captures first_err_adr.
  - i increments.
  - Goes to FIN if i was len-1, else to GAP.
- GAP:
  - Exactly one cycle with STB=0 and CYC held.
  - Required because the responder re-acknowledges only when ~ACK & STB.
  - Then returns to REQ.
- Throughput: 3 cycles/word against the zero-wait responder (REQ, REQ+ACK, GAP).
- Timeout:
  - A wait counter resets on entry to REQ.
  - Reaching TIMEOUT_CYC without ACK sets timeout_o and goes to FIN.
  - The remaining words are skipped.
- FIN:
  - CYC/STB/WE/BYTE_STB drop to 0.
  - done_o=1 for one cycle, busy_o=0.
  - Then IDLE.
- Status outputs hold until the next accepted start.
- ACK outside REQ is ignored.
- err_cnt never exceeds len (max 512), so 10 bits cannot overflow.

Decomposition:
- Shared package wb_ram_pkg:
  - Mode constants MODE_FILL=0, MODE_CHECK=1.
  - FSM state encoding.
  - RAM_WORDS=512.
  - Address field widths (ADR[8:0] word, ADR[10:9] reserved).
- Sub-module wb_ack_timeout: loadable down-counter, start/clear/expired interface, parameterised by TIMEOUT_CYC.
- FSM, address/pattern counters and compare logic stay in the top module.

Test Plan:
- FILL: RAM1, base 0x010, len 4, seed 0x1000_0000 -> RAM1[0x10..0x13] = 0x10000000..0x10000003. Bench checks:
  - exactly 4 write ACKs, one GAP cycle between them;
  - done_o pulses once;
  - RAM0/2/3 untouched.
- CHECK after that FILL, same command -> err_cnt_o=0, first_err_vld_o=0; done_o pulses 12 cycles after busy_o rises (±1 per the FSM).
- Wrap: FILL RAM2, base 0x1FE, len 4, seed 0 -> writes to addresses 0x1FE, 0x1FF, 0x000, 0x001 with data 0..3. Then corrupt RAM2[0x000] via the bridge to 0xFFFFFFFF; CHECK -> err_cnt_o=1, first_err_adr_o=0x000.
- Timeout: responder ACK tied low, FILL len 8 -> timeout_o=1 after TIMEOUT_CYC wait cycles, CYC drops, done_o pulses, no further STB.
- len=0 start -> no CYC activity, done_o pulses, status cleared.
- Extra start mid-burst -> ignored; original burst completes unchanged.
- Reset asserted mid-burst -> all bus outputs 0 immediately, busy_o=0, no done_o.

Source files
------------

// File: rtl/wb_ram_pkg.sv
// Shared definitions for the RAM test master: modes, FSM encoding and
// the RAM block address layout.
package wb_ram_pkg;

  localparam int RAM_WORDS = 512;
  localparam int NUM_RAMS  = 4;
  localparam int WORD_AW   = 9;   // ADR[8:0]: word address
  localparam int RSVD_AW   = 2;   // ADR[10:9]: reserved, driven 0
  localparam int ADR_W     = WORD_AW + RSVD_AW;

  localparam logic MODE_FILL  = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_FIN
  } state_e;

endpackage

// File: rtl/wb_ram_test_master_ack_timeout.sv
// Loadable down-counter that flags a missing ACK after TIMEOUT_CYC cycles
// spent waiting in a request.
module wb_ack_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic WBs_CLK_i,
  input  logic WBs_RST_i,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  // NOTE: every variable gets its hold value first, so no path through the
  // block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (clear_i) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (start_i) begin
      cnt_d   = CW'(TIMEOUT_CYC - 1);
      armed_d = 1'b1;
    end else if (armed_q && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  // Loaded with TIMEOUT_CYC-1 on entry, so it fires in the TIMEOUT_CYC-th REQ cycle.
  assign expired_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/wb_ram_test_master.sv
// Wishbone initiator that fills one of the four RAMs with seed+i or reads it
// back and counts words that differ from seed+i.
module wb_ram_test_master
  import wb_ram_pkg::*;
#(
  parameter int ADDRWIDTH   = 9,
  parameter int DATAWIDTH   = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 cmd_start_i,
  input  logic                 cmd_mode_i,
  input  logic [1:0]           cmd_ram_sel_i,
  input  logic [ADDRWIDTH-1:0] cmd_base_i,
  input  logic [ADDRWIDTH:0]   cmd_len_i,
  input  logic [DATAWIDTH-1:0] cmd_seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ADDRWIDTH:0]   err_cnt_o,
  output logic                 first_err_vld_o,
  output logic [ADDRWIDTH-1:0] first_err_adr_o,
  output logic                 timeout_o,
  output logic [ADDRWIDTH+1:0] WBm_ADR_o,
  output logic [NUM_RAMS-1:0]  WBm_RAM_CYC_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic                 WBm_WE_o,
  output logic                 WBm_STB_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i
);

  localparam logic [ADDRWIDTH:0] LEN_ONE = 1;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [1:0]           sel_q, sel_d;
  logic [ADDRWIDTH-1:0] adr_q, adr_d;
  logic [DATAWIDTH-1:0] pat_q, pat_d;
  logic [ADDRWIDTH:0]   rem_q, rem_d;
  logic [ADDRWIDTH:0]   err_cnt_q, err_cnt_d;
  logic                 err_vld_q, err_vld_d;
  logic [ADDRWIDTH-1:0] err_adr_q, err_adr_d;
  logic                 timeout_q, timeout_d;

  logic tmo_start, tmo_clear, tmo_expired;
  logic bus_act;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    pat_d     = pat_q;
    rem_d     = rem_q;
    err_cnt_d = err_cnt_q;
    err_vld_d = err_vld_q;
    err_adr_d = err_adr_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start_i) begin
          mode_d    = cmd_mode_i;
          sel_d     = cmd_ram_sel_i;
          adr_d     = cmd_base_i;
          pat_d     = cmd_seed_i;
          rem_d     = cmd_len_i;
          err_cnt_d = '0;
          err_vld_d = 1'b0;
          err_adr_d = '0;
          timeout_d = 1'b0;
          state_d   = (cmd_len_i == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        if (WBm_ACK_i) begin
          if (mode_q == MODE_CHECK && WBm_DAT_i != pat_q) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (!err_vld_q) begin
              err_vld_d = 1'b1;
              err_adr_d = adr_q;
            end
          end
          // Word address wraps naturally in ADDRWIDTH bits.
          adr_d   = adr_q + 1'b1;
          pat_d   = pat_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_ONE) ? ST_FIN : ST_GAP;
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_FIN;
        end
      end
      // The responder only re-acknowledges after seeing STB low for a cycle.
      ST_GAP:  state_d = ST_REQ;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign tmo_start = (state_d == ST_REQ) && (state_q != ST_REQ);
  assign tmo_clear = (state_d != ST_REQ);

  wb_ack_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_ack_timeout (
    .WBs_CLK_i (WBs_CLK_i),
    .WBs_RST_i (WBs_RST_i),
    .start_i   (tmo_start),
    .clear_i   (tmo_clear),
    .expired_o (tmo_expired)
  );

  // NOTE: asynchronous reset drops the bus immediately; non-blocking
  // assignments keep every register sampling pre-edge values.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_FILL;
      sel_q     <= '0;
      adr_q     <= '0;
      pat_q     <= '0;
      rem_q     <= '0;
      err_cnt_q <= '0;
      err_vld_q <= 1'b0;
      err_adr_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      pat_q     <= pat_d;
      rem_q     <= rem_d;
      err_cnt_q <= err_cnt_d;
      err_vld_q <= err_vld_d;
      err_adr_q <= err_adr_d;
      timeout_q <= timeout_d;
    end
  end

  // Bus outputs are decoded from registers only and are all-zero outside a burst.
  assign bus_act        = (state_q == ST_REQ) || (state_q == ST_GAP);
  assign WBm_RAM_CYC_o  = bus_act ? (NUM_RAMS'(1) << sel_q) : '0;
  assign WBm_STB_o      = (state_q == ST_REQ);
  assign WBm_WE_o       = bus_act && (mode_q == MODE_FILL);
  assign WBm_BYTE_STB_o = bus_act ? 4'hF : 4'h0;
  assign WBm_ADR_o      = bus_act ? {{RSVD_AW{1'b0}}, adr_q} : '0;
  assign WBm_DAT_o      = (bus_act && mode_q == MODE_FILL) ? pat_q : '0;

  assign busy_o          = bus_act;
  assign done_o          = (state_q == ST_FIN);
  assign err_cnt_o       = err_cnt_q;
  assign first_err_vld_o = err_vld_q;
  assign first_err_adr_o = err_adr_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_wb_ram_test_master.sv
// Bench for wb_ram_test_master: zero-wait four-RAM responder, directed
// scenarios, then random FILL/CHECK commands scored against an array model.
module tb_wb_ram_test_master;
  import wb_ram_pkg::*;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start, cmd_mode;
  logic [1:0]  cmd_sel;
  logic [8:0]  cmd_base;
  logic [9:0]  cmd_len;
  logic [31:0] cmd_seed;
  logic        busy_o, done_o, first_err_vld_o, timeout_o;
  logic [9:0]  err_cnt_o;
  logic [8:0]  first_err_adr_o;
  logic [10:0] WBm_ADR_o;
  logic [3:0]  WBm_RAM_CYC_o, WBm_BYTE_STB_o;
  logic        WBm_WE_o, WBm_STB_o, WBm_ACK_i;
  logic [31:0] WBm_DAT_o, WBm_DAT_i;

  always #5 clk = ~clk;

  wb_ram_test_master #(.ADDRWIDTH(9), .DATAWIDTH(32), .TIMEOUT_CYC(TMO)) dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst),
    .cmd_start_i(cmd_start), .cmd_mode_i(cmd_mode), .cmd_ram_sel_i(cmd_sel),
    .cmd_base_i(cmd_base), .cmd_len_i(cmd_len), .cmd_seed_i(cmd_seed),
    .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
    .first_err_vld_o(first_err_vld_o), .first_err_adr_o(first_err_adr_o),
    .timeout_o(timeout_o), .WBm_ADR_o(WBm_ADR_o), .WBm_RAM_CYC_o(WBm_RAM_CYC_o),
    .WBm_BYTE_STB_o(WBm_BYTE_STB_o), .WBm_WE_o(WBm_WE_o), .WBm_STB_o(WBm_STB_o),
    .WBm_DAT_o(WBm_DAT_o), .WBm_DAT_i(WBm_DAT_i), .WBm_ACK_i(WBm_ACK_i)
  );

  // ---------------- responder: four 512x32 RAMs, zero wait state ----------
  typedef struct packed {
    logic [1:0]  sel;
    logic [8:0]  adr;
    logic [31:0] dat;
  } wr_t;

  logic [31:0] mem [4][512];
  logic [31:0] exp_mem [4][512];
  wr_t         wr_log [1024];
  int          wr_n = 0;
  logic        resp_ack;
  logic [31:0] resp_dat;
  logic        ack_en;
  logic        bd_en;
  logic [1:0]  bd_sel;
  logic [8:0]  bd_adr;
  logic [31:0] bd_dat;

  function automatic logic [31:0] init_word(int r, int w);
    return 32'hA5A5_0000 ^ 32'(r * 4096 + w);
  endfunction

  function automatic int onehot_idx(logic [3:0] c);
    case (c)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  assign WBm_ACK_i = resp_ack;
  assign WBm_DAT_i = resp_dat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_ack <= 1'b0;
      resp_dat <= '0;
      for (int r = 0; r < 4; r++)
        for (int w = 0; w < 512; w++) mem[r][w] <= init_word(r, w);
    end else begin
      resp_ack <= 1'b0;
      if (bd_en) mem[bd_sel][bd_adr] <= bd_dat;
      if (ack_en && WBm_STB_o && !resp_ack && onehot_idx(WBm_RAM_CYC_o) >= 0) begin
        resp_ack <= 1'b1;
        resp_dat <= mem[onehot_idx(WBm_RAM_CYC_o)][WBm_ADR_o[8:0]];
        if (WBm_WE_o) begin
          mem[onehot_idx(WBm_RAM_CYC_o)][WBm_ADR_o[8:0]] <= WBm_DAT_o;
          wr_log[wr_n % 1024] <= '{sel: 2'(onehot_idx(WBm_RAM_CYC_o)),
                                  adr: WBm_ADR_o[8:0], dat: WBm_DAT_o};
          wr_n <= wr_n + 1;
        end
      end
    end
  end

  // ---------------- bus monitor (sampled on the falling edge) -------------
  int   cyc_num = 0, cyc_tot = 0, stb_tot = 0, gap_tot = 0, done_tot = 0;
  int   cyc_bad_tot = 0, done_at = 0, busy_rise_at = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc_num   <= cyc_num + 1;
    busy_prev <= busy_o;
    if (busy_o && !busy_prev) busy_rise_at <= cyc_num;
    if (done_o) begin
      done_tot <= done_tot + 1;
      done_at  <= cyc_num;
    end
    if (WBm_RAM_CYC_o != '0) cyc_tot <= cyc_tot + 1;
    if (WBm_STB_o) stb_tot <= stb_tot + 1;
    if (WBm_RAM_CYC_o != '0 && !WBm_STB_o) gap_tot <= gap_tot + 1;
    if (!$onehot0(WBm_RAM_CYC_o)) cyc_bad_tot <= cyc_bad_tot + 1;
  end

  // ---------------- checking ----------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int last_lat = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bus_idle(input string tag);
    check({tag, "_cyc"}, 32'(WBm_RAM_CYC_o), 0);
    check({tag, "_stb"}, 32'(WBm_STB_o), 0);
    check({tag, "_we"}, 32'(WBm_WE_o), 0);
    check({tag, "_bstb"}, 32'(WBm_BYTE_STB_o), 0);
    check({tag, "_adr"}, 32'(WBm_ADR_o), 0);
    check({tag, "_dat"}, WBm_DAT_o, 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_done"}, 32'(done_o), 0);
  endtask

  task automatic bd_write(input logic [1:0] s, input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_sel = s; bd_adr = a; bd_dat = d; bd_en = 1'b1;
    @(negedge clk);
    bd_en = 1'b0;
    exp_mem[s][a] = d;
  endtask

  // Issues one command, waits for done, and scores it against the model.
  // extra_at >= 0 pulses a conflicting start that many cycles into the burst.
  task automatic run_cmd(input string tag, input logic mode, input logic [1:0] sel,
                         input logic [8:0] base, input logic [9:0] len,
                         input logic [31:0] seed, input int extra_at);
    int          exp_err, nbad, diffs, bound, n;
    logic        exp_vld, exp_tmo, seen, do_wr;
    logic [8:0]  exp_fadr, a;
    int          s_cyc, s_stb, s_gap, s_done, s_wr, s_bad;
    int          exp_cyc, exp_stb, exp_gap;
    wr_t         w;

    n        = int'(len);
    exp_err  = 0;
    exp_vld  = 1'b0;
    exp_fadr = '0;
    exp_tmo  = !ack_en && n != 0;
    do_wr    = (mode == MODE_FILL) && ack_en;
    exp_cyc  = (n == 0) ? 0 : (ack_en ? 3 * n - 1 : TMO);
    exp_stb  = (n == 0) ? 0 : (ack_en ? 2 * n : TMO);
    exp_gap  = (n == 0 || !ack_en) ? 0 : n - 1;
    if (ack_en && mode == MODE_CHECK)
      for (int i = 0; i < n; i++) begin
        a = 9'((int'(base) + i) % RAM_WORDS);
        if (exp_mem[sel][a] != seed + 32'(i)) begin
          if (!exp_vld) exp_fadr = a;
          exp_vld = 1'b1;
          exp_err++;
        end
      end

    @(negedge clk);
    #1;
    s_cyc = cyc_tot; s_stb = stb_tot; s_gap = gap_tot; s_done = done_tot;
    s_wr = wr_n; s_bad = cyc_bad_tot;
    cmd_mode = mode; cmd_sel = sel; cmd_base = base; cmd_len = len; cmd_seed = seed;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;

    bound = 3 * n + TMO + 20;
    seen  = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      if (done_o) seen = 1'b1;
      else begin
        if (c == extra_at) begin
          cmd_start = 1'b1; cmd_mode = ~mode; cmd_sel = sel + 2'd1;
          cmd_base = base + 9'd100; cmd_len = 10'd3; cmd_seed = ~seed;
        end else cmd_start = 1'b0;
        @(negedge clk);
      end
    end
    cmd_start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 1);
    repeat (3) @(negedge clk);
    #1;

    check({tag, "_done_pulses"}, 32'(done_tot - s_done), 1);
    check({tag, "_cyc_cycles"}, 32'(cyc_tot - s_cyc), 32'(exp_cyc));
    check({tag, "_stb_cycles"}, 32'(stb_tot - s_stb), 32'(exp_stb));
    check({tag, "_gap_cycles"}, 32'(gap_tot - s_gap), 32'(exp_gap));
    check({tag, "_cyc_onehot"}, 32'(cyc_bad_tot - s_bad), 0);
    check({tag, "_writes"}, 32'(wr_n - s_wr), do_wr ? 32'(n) : 0);
    check({tag, "_err_cnt"}, 32'(err_cnt_o), 32'(exp_err));
    check({tag, "_err_vld"}, 32'(first_err_vld_o), 32'(exp_vld));
    check({tag, "_err_adr"}, 32'(first_err_adr_o), 32'(exp_fadr));
    check({tag, "_timeout"}, 32'(timeout_o), 32'(exp_tmo));
    check({tag, "_busy_after"}, 32'(busy_o), 0);

    nbad = 0;
    if (do_wr) begin
      for (int i = 0; i < n && s_wr + i < wr_n; i++) begin
        w = wr_log[(s_wr + i) % 1024];
        if (w.sel != sel || w.adr != 9'((int'(base) + i) % RAM_WORDS) ||
            w.dat != seed + 32'(i)) nbad++;
      end
      for (int i = 0; i < n; i++)
        exp_mem[sel][9'((int'(base) + i) % RAM_WORDS)] = seed + 32'(i);
    end
    check({tag, "_write_seq"}, 32'(nbad), 0);

    diffs = 0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 512; k++)
        if (mem[r][k] !== exp_mem[r][k]) diffs++;
    check({tag, "_ram_image"}, 32'(diffs), 0);

    last_lat = done_at - busy_rise_at;
  endtask

  // ---------------- stimulus ----------------------------------------------
  logic        r_mode;
  logic [1:0]  r_sel, f_sel;
  logic [8:0]  r_base, f_base, c_adr;
  logic [9:0]  r_len, f_len;
  logic [31:0] r_seed, f_seed;
  int          k, s_done_rst;

  initial begin
    rst = 1'b1;
    ack_en = 1'b1;
    bd_en = 1'b0; bd_sel = '0; bd_adr = '0; bd_dat = '0;
    cmd_start = 1'b0; cmd_mode = 1'b0; cmd_sel = '0; cmd_base = '0;
    cmd_len = '0; cmd_seed = '0;
    for (int r = 0; r < 4; r++)
      for (int w = 0; w < 512; w++) exp_mem[r][w] = init_word(r, w);

    repeat (3) @(negedge clk);
    check_bus_idle("reset");
    check("reset_err_cnt", 32'(err_cnt_o), 0);
    check("reset_err_vld", 32'(first_err_vld_o), 0);
    check("reset_err_adr", 32'(first_err_adr_o), 0);
    check("reset_timeout", 32'(timeout_o), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_cmd("fill1", MODE_FILL, 2'd1, 9'h010, 10'd4, 32'h1000_0000, -1);
    run_cmd("chk1", MODE_CHECK, 2'd1, 9'h010, 10'd4, 32'h1000_0000, -1);
    check("chk1_latency_ok", 32'(last_lat >= 11 && last_lat <= 13), 1);

    run_cmd("wrap_fill", MODE_FILL, 2'd2, 9'h1FE, 10'd4, 32'h0, -1);
    bd_write(2'd2, 9'h000, 32'hFFFF_FFFF);
    run_cmd("wrap_chk", MODE_CHECK, 2'd2, 9'h1FE, 10'd4, 32'h0, -1);
    check("wrap_chk_one_err", 32'(err_cnt_o), 1);
    check("wrap_chk_adr0", 32'(first_err_adr_o), 0);

    run_cmd("len0", MODE_FILL, 2'd3, 9'h005, 10'd0, 32'h7, -1);
    run_cmd("midstart", MODE_FILL, 2'd3, 9'h040, 10'd6, 32'hCAFE_0000, 4);

    f_sel = 2'd2; f_base = 9'h1FE; f_len = 10'd4; f_seed = 32'h0;
    for (int it = 0; it < 30; it++) begin
      r_mode = 1'($urandom_range(0, 1));
      if (r_mode == MODE_CHECK && $urandom_range(0, 1) == 1) begin
        r_sel = f_sel; r_base = f_base; r_len = f_len; r_seed = f_seed;
      end else begin
        r_sel  = 2'($urandom_range(0, 3));
        r_base = 9'($urandom_range(0, 511));
        r_seed = $urandom();
        k      = $urandom_range(0, 15);
        r_len  = (k == 0) ? 10'd0 : (k == 1) ? 10'd512 : 10'($urandom_range(1, 20));
      end
      if (r_mode == MODE_CHECK && r_len != 0 && $urandom_range(0, 1) == 1) begin
        c_adr = 9'((int'(r_base) + $urandom_range(0, int'(r_len) - 1)) % RAM_WORDS);
        bd_write(r_sel, c_adr, exp_mem[r_sel][c_adr] ^ ($urandom() | 32'h1));
      end
      run_cmd($sformatf("rnd%0d", it), r_mode, r_sel, r_base, r_len, r_seed, -1);
      if (r_mode == MODE_FILL && r_len != 0) begin
        f_sel = r_sel; f_base = r_base; f_len = r_len; f_seed = r_seed;
      end
    end

    ack_en = 1'b0;
    run_cmd("timeout", MODE_FILL, 2'd0, 9'h020, 10'd8, 32'h5, -1);
    check("timeout_flag", 32'(timeout_o), 1);
    check_bus_idle("timeout_after");
    ack_en = 1'b1;

    // Reset in the middle of a burst: bus drops at once, no done pulse.
    @(negedge clk);
    cmd_mode = MODE_FILL; cmd_sel = 2'd0; cmd_base = 9'h100; cmd_len = 10'd10;
    cmd_seed = 32'h1234_5678; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_busy_before", 32'(busy_o), 1);
    s_done_rst = done_tot;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_bus_idle("rst_mid");
    check("rst_mid_timeout", 32'(timeout_o), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("rst_mid_no_done", 32'(done_tot - s_done_rst), 0);
    check("rst_mid_stays_idle", 32'(busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
